// File: rtl/unicorn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : unicorn_pkg
//  Purpose  : Shared definitions for the unicorn game. Cell codes are also
//             read by the seven-segment display engine.
//  Contents : cell codes, FSM state encoding, LFSR tap mask, cell mapping
//  Revision : 1.0 - initial release
// ============================================================================
package unicorn_pkg;

  // Two-bit cell codes carried in the obstacle map
  localparam logic [1:0] CELL_EMPTY  = 2'd0;
  localparam logic [1:0] CELL_GROUND = 2'd1;
  localparam logic [1:0] CELL_OVER   = 2'd2;

  // Game FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;

  // Fibonacci taps at bits 15, 13, 12 and 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Random bits to cell code; code 3 is reserved and folds to empty
  function automatic logic [1:0] cell_from_rand(input logic [1:0] r);
    return (r == 2'd3) ? CELL_EMPTY : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter8.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter8
//  Purpose  : 8-digit packed BCD incrementer, saturating at 99999999.
//  Ports    : clk_i, rst_i   clock and synchronous active-high reset
//             clr_i          synchronous clear (highest priority)
//             ld_i/ld_val_i  synchronous load of a packed BCD value
//             en_i           increment by one
//             count_o        packed BCD count, digit 0 in [3:0]
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_counter8 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        ld_i,
  input  logic [31:0] ld_val_i,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;
  logic [31:0] w_inc;
  logic        w_all_nine;

  // Ripple the carry digit by digit; a carry surviving past digit 7 means
  // every digit is 9, which is the saturation point.
  always_comb begin
    w_inc      = count_q;
    w_all_nine = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (w_all_nine) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          w_all_nine      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (ld_i) begin
      count_d = ld_val_i;
    end else if (en_i && !w_all_nine) begin
      count_d = w_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/unicorn_game_engine.sv
`default_nettype none
// ============================================================================
//  Module   : unicorn_game_engine
//  Purpose  : Game logic feeding the seven-segment display: scrolling
//             obstacle map, jump state, start/dead status, BCD score and
//             the slow letter-scroll square wave.
//  Ports    : CLK100MHZ, reset       clock, synchronous active-high reset
//             btn_start, btn_jump    debounced button levels
//             map[15:0]              8 cells x 2 bits, cell 7 = unicorn
//             start, jump, dead      status flags
//             score[31:0]            8-digit packed BCD score
//             clk_div                square wave, toggles every SCROLL_DIV
//  Revision : 1.0 - initial release
// ============================================================================
module unicorn_game_engine
  import unicorn_pkg::*;
#(
  parameter int          TICK_DIV   = 25_000_000,
  parameter int          SCROLL_DIV = 12_500_000,
  parameter int          JUMP_TICKS = 2,
  parameter int          MIN_GAP    = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_jump,
  output logic [15:0] map,
  output logic        start,
  output logic        jump,
  output logic        dead,
  output logic [31:0] score,
  output logic        clk_div
);

  localparam logic [31:0] c_TICK_LAST   = 32'(TICK_DIV - 1);
  localparam logic [31:0] c_SCROLL_LAST = 32'(SCROLL_DIV - 1);
  localparam logic [7:0]  c_JUMP_TICKS  = 8'(JUMP_TICKS);
  localparam logic [7:0]  c_MIN_GAP     = 8'(MIN_GAP);

  logic [1:0]  state_q, state_d;
  logic [2:0]  start_sync_q, jump_sync_q;
  logic [31:0] tick_cnt_q, div_cnt_q;
  logic        clk_div_q;
  logic [15:0] lfsr_q;
  logic [15:0] map_q, map_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  jcnt_q, jcnt_d;
  logic        jump_q, jump_d;

  logic        w_start_edge, w_jump_edge, w_tick, w_div_wrap;
  logic        w_collide, w_clear, w_in_gap;
  logic [1:0]  w_new_cell;

  // Bit 0 is the first synchroniser flop; edge taken between bits 1 and 2
  assign w_start_edge = start_sync_q[1] & ~start_sync_q[2];
  assign w_jump_edge  = jump_sync_q[1]  & ~jump_sync_q[2];
  assign w_tick       = (tick_cnt_q == c_TICK_LAST);
  assign w_div_wrap   = (div_cnt_q == c_SCROLL_LAST);

  assign w_collide = (state_q == RUN) &&
                     (((map_q[15:14] == CELL_GROUND) && !jump_q) ||
                      ((map_q[15:14] == CELL_OVER)   &&  jump_q));

  // IDLE holds the play state cleared; leaving DEAD clears it on the way out
  assign w_clear = (state_q == IDLE) || ((state_q == DEAD) && w_start_edge);

  assign w_in_gap   = (gap_q < c_MIN_GAP);
  assign w_new_cell = w_in_gap ? CELL_EMPTY : cell_from_rand(lfsr_q[2:1]);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_start_edge) state_d = RUN;
      RUN:     if (w_collide)    state_d = DEAD;
      DEAD:    if (w_start_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    start = 1'b0;
    dead  = 1'b0;
    case (state_q)
      RUN:     start = 1'b1;
      DEAD:    dead  = 1'b1;
      default: ;
    endcase
  end

  // ---------------- play-field next state ----------------
  always_comb begin
    map_d  = map_q;
    gap_d  = gap_q;
    jcnt_d = jcnt_q;
    jump_d = jump_q;
    if (w_clear) begin
      map_d  = '0;
      gap_d  = '0;
      jcnt_d = '0;
      jump_d = 1'b0;
    end else if (state_q == RUN) begin
      if (w_tick) begin
        map_d = {map_q[13:0], w_new_cell};
        if (w_in_gap) begin
          gap_d = gap_q + 8'd1;
        end else if (w_new_cell != CELL_EMPTY) begin
          gap_d = '0;
        end
      end
      // A fresh jump load takes priority over a coincident tick decrement
      if (w_jump_edge && (jcnt_q == 8'd0)) begin
        jcnt_d = c_JUMP_TICKS;
        jump_d = 1'b1;
      end else if (w_tick && (jcnt_q != 8'd0)) begin
        jcnt_d = jcnt_q - 8'd1;
        if (jcnt_q == 8'd1) jump_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      start_sync_q <= '0;
      jump_sync_q  <= '0;
      tick_cnt_q   <= '0;
      div_cnt_q    <= '0;
      clk_div_q    <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      map_q        <= '0;
      gap_q        <= '0;
      jcnt_q       <= '0;
      jump_q       <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], btn_start};
      jump_sync_q  <= {jump_sync_q[1:0], btn_jump};
      tick_cnt_q   <= w_tick ? '0 : tick_cnt_q + 32'd1;
      if (w_div_wrap) begin
        div_cnt_q <= '0;
        clk_div_q <= ~clk_div_q;
      end else begin
        div_cnt_q <= div_cnt_q + 32'd1;
      end
      if (w_tick) lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      map_q  <= map_d;
      gap_q  <= gap_d;
      jcnt_q <= jcnt_d;
      jump_q <= jump_d;
    end
  end

  bcd_counter8 u_score (
    .clk_i    (CLK100MHZ),
    .rst_i    (reset),
    .clr_i    (w_clear),
    .ld_i     (1'b0),
    .ld_val_i (32'd0),
    .en_i     ((state_q == RUN) && w_tick),
    .count_o  (score)
  );

  assign map     = map_q;
  assign jump    = jump_q;
  assign clk_div = clk_div_q;

endmodule
`default_nettype wire

// File: tb/tb_unicorn_game_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unicorn_game_engine
//  Purpose  : Scoreboard bench for unicorn_game_engine plus a few direct
//             checks of the bcd_counter8 load/carry/saturation corners.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unicorn_game_engine;
  import unicorn_pkg::*;

  localparam int TICK_DIV   = 4;
  localparam int SCROLL_DIV = 3;
  localparam int JUMP_TICKS = 2;
  localparam int MIN_GAP    = 2;
  localparam int SCORE_MAX  = 99999999;
  localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2;

  logic        CLK100MHZ = 1'b0;
  logic        reset     = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_jump  = 1'b0;
  logic [15:0] map;
  logic        start, jump, dead, clk_div;
  logic [31:0] score;

  logic        b_clr = 1'b0, b_ld = 1'b0, b_en = 1'b0;
  logic [31:0] b_val = 32'd0;
  logic [31:0] b_count;

  int n_checks = 0;
  int n_fail   = 0;
  int jmode    = 0;   // 0 idle, 1 autopilot, 2 random
  int ap_cnt   = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  unicorn_game_engine #(
    .TICK_DIV   (TICK_DIV),
    .SCROLL_DIV (SCROLL_DIV),
    .JUMP_TICKS (JUMP_TICKS),
    .MIN_GAP    (MIN_GAP),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_jump  (btn_jump),
    .map       (map),
    .start     (start),
    .jump      (jump),
    .dead      (dead),
    .score     (score),
    .clk_div   (clk_div)
  );

  bcd_counter8 u_bcd (
    .clk_i    (CLK100MHZ),
    .rst_i    (reset),
    .clr_i    (b_clr),
    .ld_i     (b_ld),
    .ld_val_i (b_val),
    .en_i     (b_en),
    .count_o  (b_count)
  );

  // ---------------- reference model (game rules, integer arithmetic) ----
  int m_state, m_tcnt, m_dcnt, m_gap, m_jcnt, m_score, m_lfsr;
  int m_cell [8];
  bit m_cd;
  bit [2:0] m_hs, m_hj;   // button samples, [0] newest

  typedef struct packed {
    logic [15:0] map;
    logic        start;
    logic        jump;
    logic        dead;
    logic [31:0] score;
    logic        clk_div;
  } obs_t;

  obs_t exp_q[$];

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    for (int i = 0; i < 8; i++) o.map[2*i +: 2] = 2'(m_cell[i]);
    o.start   = (m_state == M_RUN);
    o.jump    = (m_jcnt != 0);
    o.dead    = (m_state == M_DEAD);
    o.score   = to_bcd(m_score);
    o.clk_div = m_cd;
    return o;
  endfunction

  always @(posedge CLK100MHZ) begin : model_p
    bit se, je, tk, coll, clr;
    int nc, rr, fb;
    if (reset) begin
      m_state = M_IDLE; m_tcnt = 0; m_dcnt = 0; m_gap = 0; m_jcnt = 0;
      m_score = 0; m_lfsr = 'hACE1; m_cd = 1'b0; m_hs = '0; m_hj = '0;
      for (int i = 0; i < 8; i++) m_cell[i] = 0;
    end else begin
      se   = m_hs[1] && !m_hs[2];
      je   = m_hj[1] && !m_hj[2];
      tk   = (m_tcnt == TICK_DIV - 1);
      coll = (m_state == M_RUN) &&
             ((m_cell[7] == 1 && m_jcnt == 0) || (m_cell[7] == 2 && m_jcnt != 0));
      clr  = (m_state == M_IDLE) || (m_state == M_DEAD && se);
      rr   = (m_lfsr >> 1) & 3;
      nc   = (m_gap < MIN_GAP || rr == 3) ? 0 : rr;
      if (clr) begin
        for (int i = 0; i < 8; i++) m_cell[i] = 0;
        m_score = 0; m_gap = 0; m_jcnt = 0;
      end else if (m_state == M_RUN) begin
        if (tk) begin
          for (int i = 7; i > 0; i--) m_cell[i] = m_cell[i-1];
          m_cell[0] = nc;
          if (m_score < SCORE_MAX) m_score = m_score + 1;
          if (m_gap < MIN_GAP) m_gap = m_gap + 1;
          else if (nc != 0) m_gap = 0;
        end
        if (je && m_jcnt == 0) m_jcnt = JUMP_TICKS;
        else if (tk && m_jcnt > 0) m_jcnt = m_jcnt - 1;
      end
      case (m_state)
        M_IDLE:  if (se) m_state = M_RUN;
        M_RUN:   if (coll) m_state = M_DEAD;
        default: if (se) m_state = M_IDLE;
      endcase
      if (tk) begin
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
      end
      m_tcnt = tk ? 0 : m_tcnt + 1;
      if (m_dcnt == SCROLL_DIV - 1) begin
        m_dcnt = 0;
        m_cd   = !m_cd;
      end else begin
        m_dcnt = m_dcnt + 1;
      end
      m_hs = {m_hs[1:0], btn_start};
      m_hj = {m_hj[1:0], btn_jump};
    end
    exp_q.push_back(model_obs());
  end

  // ---------------- monitor: one expected observation per cycle ----------
  always @(negedge CLK100MHZ) begin : monitor_p
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {map, start, jump, dead, score, clk_div};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got map=%h start=%b jump=%b dead=%b score=%h clk_div=%b, want map=%h start=%b jump=%b dead=%b score=%h clk_div=%b",
                 $time, a.map, a.start, a.jump, a.dead, a.score, a.clk_div,
                 e.map, e.start, e.jump, e.dead, e.score, e.clk_div);
      end
    end
  end

  // ---------------- jump button driver ----------------
  // Autopilot presses when a ground block has just entered cell 6, so the
  // jump is airborne for the whole time the block sits in cell 7; a second
  // press follows while airborne and must be ignored.
  always @(negedge CLK100MHZ) begin : jump_drv
    if (jmode == 1) begin
      if (ap_cnt > 0) begin
        btn_jump = (ap_cnt == 2);
        ap_cnt--;
      end else if (m_state == M_RUN && m_cell[6] == int'(CELL_GROUND) &&
                   m_tcnt == 0 && m_jcnt == 0) begin
        btn_jump = 1'b1;
        ap_cnt   = 3;
      end else begin
        btn_jump = 1'b0;
      end
    end else if (jmode == 2) begin
      btn_jump = ($urandom_range(0, 3) == 0);
    end else begin
      btn_jump = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic press_start();
    @(negedge CLK100MHZ) btn_start = 1'b1;
    repeat (3) @(negedge CLK100MHZ);
    btn_start = 1'b0;
    repeat (4) @(negedge CLK100MHZ);
  endtask

  task automatic wait_score(input string name, input int target, input int budget);
    int i;
    for (i = 0; i < budget && m_score < target; i++) @(negedge CLK100MHZ);
    if (m_score < target) begin
      n_checks++; n_fail++;
      $display("FAIL %s: score %0d did not reach %0d within %0d cycles", name, m_score, target, budget);
    end else begin
      check_val(name, 64'(score), 64'(to_bcd(target)));
    end
  endtask

  task automatic bcd_op(input string name, input logic clr, input logic ld, input logic en,
                        input logic [31:0] val, input logic [31:0] req);
    b_clr = clr; b_ld = ld; b_en = en; b_val = val;
    @(negedge CLK100MHZ);
    check_val(name, 64'(b_count), 64'(req));
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim_p
    int saved;
    int i;
    repeat (3) @(negedge CLK100MHZ);
    reset = 1'b0;
    repeat (20) @(negedge CLK100MHZ);

    // Long survival run with the autopilot: crosses score 99 -> 100
    jmode = 1;
    press_start();
    check_val("start_after_edge", 64'(start), 64'd1);
    wait_score("score_ten", 10, 200);
    wait_score("score_120", 120, 1000);

    // Stop jumping and let the unicorn hit a ground block
    jmode = 0;
    for (i = 0; i < 1200 && m_state != M_DEAD; i++) @(negedge CLK100MHZ);
    if (m_state != M_DEAD) begin
      n_checks++; n_fail++;
      $display("FAIL death_wait: model never reached DEAD within 1200 cycles");
    end else begin
      check_val("dead_flag", 64'({dead, start}), 64'b10);
      saved = m_score;
      repeat (12) @(negedge CLK100MHZ);
      check_val("score_frozen", 64'(score), 64'(to_bcd(saved)));
    end

    // DEAD -> IDLE clears the board, then IDLE -> RUN
    press_start();
    check_val("idle_clear", {map, score, start, dead, jump}, 64'd0);
    press_start();
    check_val("restart_run", 64'(start), 64'd1);

    // Random jumps, then reset in the middle of play
    jmode = 2;
    repeat (200) @(negedge CLK100MHZ);
    reset = 1'b1;
    @(negedge CLK100MHZ);
    check_val("mid_reset", {map, score, start, dead, jump, clk_div}, 64'd0);
    reset = 1'b0;

    // Free-running random phase on both buttons and occasional reset
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLK100MHZ);
      if ($urandom_range(0, 40) == 0) btn_start = ~btn_start;
      reset = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0; btn_start = 1'b0; jmode = 0;
    repeat (3) @(negedge CLK100MHZ);

    // Score counter corners: carry ripple, saturation, clear priority
    bcd_op("bcd_load99",   1'b0, 1'b1, 1'b0, 32'h00000099, 32'h00000099);
    bcd_op("bcd_99_to_100",1'b0, 1'b0, 1'b1, 32'h0,        32'h00000100);
    bcd_op("bcd_load1999", 1'b0, 1'b1, 1'b0, 32'h00001999, 32'h00001999);
    bcd_op("bcd_to_2000",  1'b0, 1'b0, 1'b1, 32'h0,        32'h00002000);
    bcd_op("bcd_load_max1",1'b0, 1'b1, 1'b0, 32'h99999998, 32'h99999998);
    bcd_op("bcd_to_max",   1'b0, 1'b0, 1'b1, 32'h0,        32'h99999999);
    bcd_op("bcd_saturate", 1'b0, 1'b0, 1'b1, 32'h0,        32'h99999999);
    bcd_op("bcd_hold",     1'b0, 1'b0, 1'b0, 32'h0,        32'h99999999);
    bcd_op("bcd_clr_wins", 1'b1, 1'b0, 1'b1, 32'h0,        32'h00000000);
    bcd_op("bcd_load_9s",  1'b0, 1'b1, 1'b0, 32'h09999999, 32'h09999999);
    bcd_op("bcd_full_carry",1'b0,1'b0, 1'b1, 32'h0,        32'h10000000);
    b_en = 1'b0;

    repeat (2) @(negedge CLK100MHZ);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
